wb_unit: RTL
============

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 2, consecutive load wins allowed while an ALU result waits.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports alu_valid input 1, alu_ready output 1, alu_rd input 5, alu_data input 64: ALU result handshake.
REQ-005 SHALL have ports ld_valid input 1, ld_ready output 1, ld_rd input 5, ld_data input 64, ld_size input 2 (0=B,1=H,2=W,3=D), ld_unsigned input 1: load-return handshake.
REQ-006 SHALL have ports iss_en input 1, iss_rd input 5: issue-side marking of a pending destination.
REQ-007 SHALL have ports wb_en output 1, wb_addr output 5, wb_data output 64: register-file write port, all registered.
REQ-008 SHALL have port busy output 32: per-register pending-write scoreboard, bit 0 always 0.

Function
REQ-009 SHALL accept a source beat when valid && ready in the same cycle; data captured into that source's one-entry holding register.
REQ-010 SHALL drive ready = holding register empty OR holding register drains this cycle (full-rate, no bubble).
REQ-011 SHALL select at most one holding register per cycle; the winner is written to wb_* on the next edge (1-cycle latency from holding to wb_en).
REQ-012 SHALL give load priority; after STARVE_MAX consecutive load wins with ALU holding full, ALU SHALL win the next cycle and the counter SHALL clear.
REQ-013 SHALL clear the starvation counter whenever ALU wins or ALU holding is empty.
REQ-014 SHALL sign-extend (ld_unsigned=0) or zero-extend (ld_unsigned=1) ld_data[7:0]/[15:0]/[31:0] per ld_size at capture; size 3 passes 64 bits unchanged.
REQ-015 SHALL consume results with rd=0 normally but SHALL hold wb_en low for them.
REQ-016 SHALL deassert wb_en in any cycle with no winner; wb_addr/wb_data hold prior values.
REQ-017 SHALL set busy[iss_rd] on iss_en (iss_rd≠0) and clear busy[wb_addr] on wb_en, effective next edge.
REQ-018 SHALL let set win when iss_en and wb_en target the same register in the same cycle.
REQ-019 SHALL treat both holding registers full with neither selectable as impossible; arbitration always picks one when any is full.

Reset
REQ-020 SHALL, on reset assertion, asynchronously clear wb_en, wb_addr, wb_data, busy, both holding-valid bits and the starvation counter.
REQ-021 SHALL drive alu_ready=ld_ready=1 from the first edge after reset deassertion.
REQ-022 SHALL discard any in-flight held results on reset mid-operation; no write issued for them.

Configuration
REQ-023 SHALL, with WB_BYPASS_EN defined, add outputs byp_valid 1, byp_addr 5, byp_data 64 that combinationally present the arbitration winner of the current cycle (rd≠0) for operand forwarding.
REQ-024 SHALL, without WB_BYPASS_EN, omit those ports entirely with all other behaviour identical.

Structure
REQ-025 SHALL place the ld_size encoding enum and XLEN=64 constant in the shared core package.
REQ-026 SHALL implement load extension in sub-module load_ext (pure combinational, size/unsigned/data in, 64-bit out).

Verification
REQ-027 SHALL cover: alu_valid, rd=5, data=0x1234 -> wb_en=1, wb_addr=5, wb_data=0x1234 two edges later; busy[5] cleared if previously issued.
REQ-028 SHALL cover: ld_data=0x80, size=0, unsigned=0, rd=3 -> wb_data=0xFFFF_FFFF_FFFF_FF80; same with unsigned=1 -> 0x80.
REQ-029 SHALL cover: both sources valid every cycle, STARVE_MAX=2 -> wb order L,L,A,L,L,A; no beat lost or duplicated.
REQ-030 SHALL cover: alu rd=0 data=0xDEAD -> accepted, wb_en stays 0.
REQ-031 SHALL cover: iss_en rd=7 same cycle as wb_en addr=7 -> busy[7]=1 afterwards.
REQ-032 SHALL cover: reset asserted with both holdings full -> wb_en=0, busy=0 immediately, no later writes; with WB_BYPASS_EN, byp_valid tracks winner same cycle.

Source files
------------

// File: rtl/wb_unit_pkg.sv
// Shared core package: datapath width and load-size encoding used by the
// writeback unit and its load-extension helper.
package wb_unit_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } ld_size_e;

endpackage

// File: rtl/wb_unit_load_ext.sv
// Combinational load-data extension: sign- or zero-extends the low byte,
// half or word of a load return to XLEN bits; doublewords pass unchanged.
module load_ext
    import wb_unit_pkg::*;
(
    input  ld_size_e          size,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   data,
    output logic [XLEN-1:0]   result
);

    always_comb begin
        result = data;
        unique case (size)
            SIZE_B: result = {{(XLEN-8){~is_unsigned & data[7]}}, data[7:0]};
            SIZE_H: result = {{(XLEN-16){~is_unsigned & data[15]}}, data[15:0]};
            SIZE_W: result = {{(XLEN-32){~is_unsigned & data[31]}}, data[31:0]};
            SIZE_D: result = data;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback arbiter: merges ALU and load results into one register-file
// write port with a pending-write scoreboard. Optional forwarding ports: WB_BYPASS_EN.
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 2
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic            iss_en,
    input  logic [4:0]      iss_rd,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
`ifdef WB_BYPASS_EN
    output logic            byp_valid,
    output logic [4:0]      byp_addr,
    output logic [XLEN-1:0] byp_data,
`endif
    output logic [31:0]     busy
);

    localparam int unsigned     CW         = $clog2(STARVE_MAX + 2);
    localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_MAX);

    logic            alu_hv, ld_hv;
    logic [4:0]      alu_hrd, ld_hrd;
    logic [XLEN-1:0] alu_hdata, ld_hdata, ld_ext;
    logic [CW-1:0]   starve_cnt;
    logic            alu_win, ld_win, win_any, win_wr;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic [31:0]     busy_nxt;

    load_ext u_load_ext (
        .size        (ld_size_e'(ld_size)),
        .is_unsigned (ld_unsigned),
        .data        (ld_data),
        .result      (ld_ext)
    );

    // Load wins unless the ALU has already been passed over STARVE_MAX times.
    always_comb begin
        alu_win = 1'b0;
        ld_win  = 1'b0;
        if (ld_hv && !(alu_hv && starve_cnt >= STARVE_LIM))
            ld_win = 1'b1;
        else if (alu_hv)
            alu_win = 1'b1;
        win_any  = alu_win | ld_win;
        win_rd   = ld_win ? ld_hrd : alu_hrd;
        win_data = ld_win ? ld_hdata : alu_hdata;
        win_wr   = win_any && (win_rd != '0);
    end

    assign alu_ready = !alu_hv || alu_win;
    assign ld_ready  = !ld_hv  || ld_win;

`ifdef WB_BYPASS_EN
    assign byp_valid = win_wr;
    assign byp_addr  = win_rd;
    assign byp_data  = win_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_hv    <= 1'b0;
            alu_hrd   <= '0;
            alu_hdata <= '0;
            ld_hv     <= 1'b0;
            ld_hrd    <= '0;
            ld_hdata  <= '0;
        end else begin
            if (alu_valid && alu_ready) begin
                alu_hv    <= 1'b1;
                alu_hrd   <= alu_rd;
                alu_hdata <= alu_data;
            end else if (alu_win) begin
                alu_hv <= 1'b0;
            end
            if (ld_valid && ld_ready) begin
                ld_hv    <= 1'b1;
                ld_hrd   <= ld_rd;
                ld_hdata <= ld_ext;
            end else if (ld_win) begin
                ld_hv <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (!alu_hv || alu_win)
            starve_cnt <= '0;
        else if (ld_win && starve_cnt < STARVE_LIM)
            starve_cnt <= starve_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= win_wr;
            if (win_wr) begin
                wb_addr <= win_rd;
                wb_data <= win_data;
            end
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the bit pending.
    always_comb begin
        busy_nxt = busy;
        if (wb_en)
            busy_nxt[wb_addr] = 1'b0;
        if (iss_en && iss_rd != '0)
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule
